execute_unit: RTL and testbench

//   Execute stage of the 8-bit multi-cycle processor. Sits between the register

---
 rtl/execute_unit_if.sv | 35 +++
 rtl/execute_unit.sv | 159 +++++++++++++++
 tb/tb_execute_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/execute_unit_if.sv
// Execute-stage bus between the state controller / register file (master)
// and the execute unit (slave).
//
// Handshake: the controller requests an operation by holding state at
// STATE_EX with the instruction fields and operands stable; the unit starts
// on the first edge it sees that request while idle (ex_busy=0, ex_done=0).
// ex_done acts as "valid" for result/instruction_invalid and stays high for as
// long as state remains STATE_EX; the controller "accepts" by leaving
// STATE_EX, which clears ex_done on the next edge. Leaving while ex_busy=1 is
// a protocol violation and aborts the multiply without producing a result.
interface execute_unit_if #(
    parameter int DATA_W = 8
);
    logic [2:0]        state;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        shamt;
    logic [15:0]       imm;
    logic [DATA_W-1:0] rsv;
    logic [DATA_W-1:0] rtv;
    logic [DATA_W-1:0] result;
    logic              instruction_invalid;
    logic              ex_busy;
    logic              ex_done;

    modport master (
        output state, opcode, funct, shamt, imm, rsv, rtv,
        input  result, instruction_invalid, ex_busy, ex_done
    );

    modport slave (
        input  state, opcode, funct, shamt, imm, rsv, rtv,
        output result, instruction_invalid, ex_busy, ex_done
    );
endinterface

// File: rtl/execute_unit.sv
// Execute stage of the 8-bit multi-cycle processor. Single-cycle ALU ops
// complete on the start edge; mul runs an iterative shift-add over DATA_W
// cycles. All outputs are registered.
module execute_unit #(
    parameter int          DATA_W   = 8,
    parameter logic [2:0]  STATE_EX = 3'd3
) (
    input  logic           clk,
    input  logic           rst_n,
    execute_unit_if.slave  ex_if,
    output logic [1:0]     fsm_state_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_MUL = 6'h18;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } ex_state_e;

    ex_state_e         state_q;
    logic [DATA_W-1:0] result_q;
    logic              invalid_q;
    logic              busy_q;
    logic              done_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [CNT_W-1:0]  count_q;

    logic [DATA_W-1:0] alu_result_d;
    logic              alu_invalid_d;
    logic              is_mul_d;
    logic [DATA_W-1:0] imm8;
    logic              shift_oor;
    logic              in_ex;
    logic [DATA_W-1:0] acc_d;

    assign imm8      = ex_if.imm[DATA_W-1:0];
    assign shift_oor = (int'(ex_if.shamt) >= DATA_W);
    assign in_ex     = (ex_if.state == STATE_EX);

    // One shift-add step: add the multiplicand when the current multiplier bit is set.
    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Decode the instruction and compute the single-cycle result from live operands.
    always_comb begin
        alu_result_d  = '0;
        alu_invalid_d = 1'b0;
        is_mul_d      = 1'b0;
        case (ex_if.opcode)
            OP_RTYPE: begin
                case (ex_if.funct)
                    FN_ADD: alu_result_d = ex_if.rsv + ex_if.rtv;
                    FN_SUB: alu_result_d = ex_if.rsv - ex_if.rtv;
                    FN_AND: alu_result_d = ex_if.rsv & ex_if.rtv;
                    FN_OR:  alu_result_d = ex_if.rsv | ex_if.rtv;
                    FN_SLT: alu_result_d = {{(DATA_W-1){1'b0}},
                                            ($signed(ex_if.rsv) < $signed(ex_if.rtv))};
                    FN_SLL: alu_result_d = shift_oor ? '0 : (ex_if.rtv << ex_if.shamt);
                    FN_SRL: alu_result_d = shift_oor ? '0 : (ex_if.rtv >> ex_if.shamt);
                    FN_MUL: is_mul_d     = 1'b1;
                    default: alu_invalid_d = 1'b1;
                endcase
            end
            OP_ADDI: alu_result_d = ex_if.rsv + imm8;
            OP_ANDI: alu_result_d = ex_if.rsv & imm8;
            OP_ORI:  alu_result_d = ex_if.rsv | imm8;
            default: alu_invalid_d = 1'b1;
        endcase
    end

    // Execute FSM: start/decode, iterative multiply, and result hold until STATE_EX is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            invalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_ex) begin
                        invalid_q <= alu_invalid_d;
                        if (is_mul_d) begin
                            // Operands are captured here so later rsv/rtv changes are ignored.
                            busy_q   <= 1'b1;
                            acc_q    <= '0;
                            mcand_q  <= ex_if.rsv;
                            mplier_q <= ex_if.rtv;
                            count_q  <= CNT_W'(DATA_W);
                            state_q  <= S_MUL;
                        end else begin
                            result_q <= alu_result_d;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    if (!in_ex) begin
                        // Controller left early: drop the multiply, keep the old result.
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        count_q  <= count_q - 1'b1;
                        if (count_q == CNT_W'(1)) begin
                            result_q <= acc_d;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!in_ex) begin
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ex_if.result              = result_q;
    assign ex_if.instruction_invalid = invalid_q;
    assign ex_if.ex_busy             = busy_q;
    assign ex_if.ex_done             = done_q;
    assign fsm_state_o               = state_q;

endmodule

// File: tb/tb_execute_unit.sv
// Directed testbench for execute_unit: ALU ops, immediates, invalid
// encodings, shift-add multiply, early exit and asynchronous reset.
module tb_execute_unit;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_EX   = 3'd3;
    localparam logic [2:0] ST_WB   = 3'd4;

    logic       clk;
    logic       rst_n;
    logic [1:0] fsm_state;

    int checks;
    int errors;

    logic [7:0] exp_q[$];

    execute_unit_if #(.DATA_W(8)) ex_if ();

    execute_unit #(.DATA_W(8), .STATE_EX(ST_EX)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_if       (ex_if),
        .fsm_state_o (fsm_state)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_op(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                            input logic [15:0] im, input logic [7:0] a, input logic [7:0] b);
        ex_if.opcode = op;
        ex_if.funct  = fn;
        ex_if.shamt  = sh;
        ex_if.imm    = im;
        ex_if.rsv    = a;
        ex_if.rtv    = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle op: done one edge after entering EX, hold in EX, clear on WB.
    task automatic run_single(input string tag, input logic [5:0] op, input logic [5:0] fn,
                              input logic [4:0] sh, input logic [15:0] im,
                              input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] exp_res, input logic exp_inv);
        logic [7:0] e;
        drive_op(op, fn, sh, im, a, b);
        exp_q.push_back(exp_res);
        ex_if.state = ST_EX;
        tick();
        e = exp_q.pop_front();
        check({tag, "_done"}, {31'd0, ex_if.ex_done}, 32'd1);
        check({tag, "_inv"}, {31'd0, ex_if.instruction_invalid}, {31'd0, exp_inv});
        check({tag, "_res"}, {24'd0, ex_if.result}, {24'd0, e});
        tick();
        check({tag, "_hold"}, {23'd0, ex_if.ex_done, ex_if.result}, {23'd0, 1'b1, e});
        ex_if.state = ST_WB;
        tick();
        check({tag, "_wb"}, {22'd0, ex_if.ex_done, ex_if.instruction_invalid, ex_if.result},
              {22'd0, 1'b0, exp_inv, e});
        ex_if.state = ST_IDLE;
        tick();
    endtask

    // Multiply: busy for 8 edges, done at edge 9; operands scrambled after start.
    task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_res);
        logic [7:0] e;
        drive_op(6'h00, 6'h18, 5'd0, 16'h0000, a, b);
        exp_q.push_back(exp_res);
        ex_if.state = ST_EX;
        for (int edge_n = 1; edge_n <= 8; edge_n++) begin
            tick();
            check($sformatf("%s_busy_e%0d", tag, edge_n),
                  {30'd0, ex_if.ex_busy, ex_if.ex_done}, 32'd2);
            ex_if.rsv = 8'($urandom_range(0, 255));
            ex_if.rtv = 8'($urandom_range(0, 255));
        end
        tick();
        e = exp_q.pop_front();
        check({tag, "_done"}, {30'd0, ex_if.ex_busy, ex_if.ex_done}, 32'd1);
        check({tag, "_res"}, {24'd0, ex_if.result}, {24'd0, e});
        check({tag, "_inv"}, {31'd0, ex_if.instruction_invalid}, 32'd0);
        ex_if.state = ST_WB;
        tick();
        check({tag, "_wb"}, {23'd0, ex_if.ex_done, ex_if.result}, {23'd0, 1'b0, e});
        ex_if.state = ST_IDLE;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        ex_if.state = ST_IDLE;
        drive_op(6'h00, 6'h00, 5'd0, 16'h0000, 8'h00, 8'h00);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", {21'd0, ex_if.result, ex_if.instruction_invalid, ex_if.ex_busy,
              ex_if.ex_done}, 32'd0);
        check("reset_fsm", {30'd0, fsm_state}, 32'd0);
        rst_n = 1'b1;
        tick();

        // ALU directed vectors
        run_single("add",  6'h00, 6'h20, 5'd0, 16'h0000, 8'hF0, 8'h20, 8'h10, 1'b0);
        run_single("sub",  6'h00, 6'h22, 5'd0, 16'h0000, 8'h05, 8'h07, 8'hFE, 1'b0);
        run_single("and",  6'h00, 6'h24, 5'd0, 16'h0000, 8'hCC, 8'hAA, 8'h88, 1'b0);
        run_single("or",   6'h00, 6'h25, 5'd0, 16'h0000, 8'hCC, 8'hAA, 8'hEE, 1'b0);
        run_single("slt1", 6'h00, 6'h2a, 5'd0, 16'h0000, 8'h80, 8'h01, 8'h01, 1'b0);
        run_single("slt0", 6'h00, 6'h2a, 5'd0, 16'h0000, 8'h01, 8'h80, 8'h00, 1'b0);
        run_single("sll1", 6'h00, 6'h00, 5'd1, 16'h0000, 8'h00, 8'h81, 8'h02, 1'b0);
        run_single("sll8", 6'h00, 6'h00, 5'd8, 16'h0000, 8'h00, 8'hFF, 8'h00, 1'b0);
        run_single("srl7", 6'h00, 6'h02, 5'd7, 16'h0000, 8'h00, 8'h80, 8'h01, 1'b0);
        run_single("srl9", 6'h00, 6'h02, 5'd9, 16'h0000, 8'h00, 8'hFF, 8'h00, 1'b0);
        run_single("addi", 6'h08, 6'h00, 5'd0, 16'hFFFF, 8'h05, 8'h00, 8'h04, 1'b0);
        run_single("andi", 6'h0c, 6'h00, 5'd0, 16'h120F, 8'hF3, 8'h00, 8'h03, 1'b0);
        run_single("ori",  6'h0d, 6'h00, 5'd0, 16'h000A, 8'h50, 8'h00, 8'h5A, 1'b0);

        // Invalid encodings and recovery
        run_single("bad_op",  6'h3F, 6'h20, 5'd0, 16'h0000, 8'h11, 8'h22, 8'h00, 1'b1);
        run_single("clr_inv", 6'h00, 6'h20, 5'd0, 16'h0000, 8'h01, 8'h02, 8'h03, 1'b0);
        run_single("bad_fn",  6'h00, 6'h3F, 5'd0, 16'h0000, 8'h11, 8'h22, 8'h00, 1'b1);

        // Multiply
        run_mul("mul_0d0b", 8'h0D, 8'h0B, 8'h8F);
        run_mul("mul_ffff", 8'hFF, 8'hFF, 8'h01);

        // Early exit at mul cycle 4: abort, result keeps previous value
        drive_op(6'h00, 6'h18, 5'd0, 16'h0000, 8'h03, 8'h05);
        ex_if.state = ST_EX;
        repeat (4) tick();
        ex_if.state = ST_WB;
        tick();
        check("abort_outs", {22'd0, ex_if.ex_busy, ex_if.ex_done, ex_if.result},
              {22'd0, 1'b0, 1'b0, 8'h01});
        check("abort_fsm", {30'd0, fsm_state}, 32'd0);
        ex_if.state = ST_IDLE;
        tick();
        run_mul("mul_restart", 8'h03, 8'h05, 8'h0F);

        // Asynchronous reset mid-multiply
        drive_op(6'h00, 6'h18, 5'd0, 16'h0000, 8'h07, 8'h09);
        ex_if.state = ST_EX;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("async_rst", {21'd0, ex_if.result, ex_if.instruction_invalid, ex_if.ex_busy,
              ex_if.ex_done}, 32'd0);
        ex_if.state = ST_IDLE;
        #2;
        rst_n = 1'b1;
        tick();
        check("post_rst_fsm", {30'd0, fsm_state}, 32'd0);
        run_mul("mul_after_rst", 8'h07, 8'h09, 8'h3F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
